// File: rtl/fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : fb_write_arbiter
// Brief   : Round-robin merge of queued CPU pixel writes and a linear fill
//           engine onto a single registered frame buffer write port.
// Rev     : 1.0  initial release
// ============================================================================
module fb_write_arbiter #(
  parameter int CPU_FIFO_DEPTH = 4,
  parameter int PIX_PER_PLANE  = 98304
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_valid,
  output logic        cpu_req_ready,
  input  logic [19:0] cpu_req_addr,
  input  logic        cpu_req_data,
  input  logic        fill_start,
  input  logic [19:0] fill_base,
  input  logic [16:0] fill_count,
  input  logic        fill_data,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        arb_we,
  output logic [19:0] arb_addr,
  output logic        arb_din
);

  localparam int          c_PTR_W    = $clog2(CPU_FIFO_DEPTH);
  localparam logic [17:0] c_PIX_LIM  = 18'(PIX_PER_PLANE);
  localparam logic [16:0] c_PIX_LAST = 17'(PIX_PER_PLANE - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } fill_state_t;

  // --------------------------------------------------------------------------
  // CPU write FIFO: {addr, data} entries, extra pointer bit separates full/empty
  // --------------------------------------------------------------------------
  logic [20:0]        r_fifo_mem [CPU_FIFO_DEPTH];
  logic [c_PTR_W:0]   r_wr_ptr;
  logic [c_PTR_W:0]   r_rd_ptr;
  logic               r_live;
  logic               w_fifo_empty;
  logic               w_fifo_full;
  logic               w_push;
  logic               w_pop;
  logic [20:0]        w_fifo_head;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                        (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
  assign w_fifo_head  = r_fifo_mem[r_rd_ptr[c_PTR_W-1:0]];

  // r_live holds ready low until the first edge after reset is released
  assign cpu_req_ready = r_live && !w_fifo_full;
  assign w_push        = cpu_req_valid && cpu_req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_live   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_live <= 1'b1;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[c_PTR_W-1:0]] <= {cpu_req_addr, cpu_req_data};
    end
  end

  // --------------------------------------------------------------------------
  // Fill engine
  // --------------------------------------------------------------------------
  fill_state_t  r_state;
  fill_state_t  w_state_nxt;
  logic [2:0]   r_fill_plane;
  logic [16:0]  r_fill_pix;
  logic [16:0]  r_fill_left;
  logic         r_fill_data;
  logic         w_fill_ok;
  logic         w_fill_accept;
  logic         w_gnt_cpu;
  logic         w_gnt_fill;

  assign w_fill_ok     = (fill_count != 17'd0) && ({1'b0, fill_base[16:0]} < c_PIX_LIM);
  assign w_fill_accept = (r_state == ST_IDLE) && fill_start && w_fill_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (fill_start) begin
          w_state_nxt = w_fill_ok ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_gnt_fill && (r_fill_left == 17'd1)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill_plane <= '0;
      r_fill_pix   <= '0;
      r_fill_left  <= '0;
      r_fill_data  <= 1'b0;
    end else if (w_fill_accept) begin
      r_fill_plane <= fill_base[19:17];
      r_fill_pix   <= fill_base[16:0];
      r_fill_left  <= fill_count;
      r_fill_data  <= fill_data;
    end else if (w_gnt_fill) begin
      r_fill_pix  <= (r_fill_pix == c_PIX_LAST) ? 17'd0 : r_fill_pix + 17'd1;
      r_fill_left <= r_fill_left - 17'd1;
    end
  end

  assign fill_busy = (r_state == ST_RUN);
  assign fill_done = (r_state == ST_DONE);

  // --------------------------------------------------------------------------
  // Arbitration: r_rr_fill set means the fill wins the next contended cycle
  // --------------------------------------------------------------------------
  logic w_cpu_pend;
  logic w_fill_pend;
  logic r_rr_fill;

  assign w_cpu_pend  = !w_fifo_empty;
  assign w_fill_pend = (r_state == ST_RUN);
  assign w_gnt_cpu   = w_cpu_pend && (!w_fill_pend || !r_rr_fill);
  assign w_gnt_fill  = w_fill_pend && (!w_cpu_pend || r_rr_fill);
  assign w_pop       = w_gnt_cpu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_fill <= 1'b0;
    end else if (w_cpu_pend && w_fill_pend) begin
      r_rr_fill <= w_gnt_cpu;
    end
  end

  // --------------------------------------------------------------------------
  // Registered write port; address and data hold when nothing is granted
  // --------------------------------------------------------------------------
  logic        r_arb_we;
  logic [19:0] r_arb_addr;
  logic        r_arb_din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arb_we   <= 1'b0;
      r_arb_addr <= '0;
      r_arb_din  <= 1'b0;
    end else begin
      r_arb_we <= w_gnt_cpu || w_gnt_fill;
      if (w_gnt_cpu) begin
        r_arb_addr <= w_fifo_head[20:1];
        r_arb_din  <= w_fifo_head[0];
      end else if (w_gnt_fill) begin
        r_arb_addr <= {r_fill_plane, r_fill_pix};
        r_arb_din  <= r_fill_data;
      end
    end
  end

  assign arb_we   = r_arb_we;
  assign arb_addr = r_arb_addr;
  assign arb_din  = r_arb_din;

endmodule
`default_nettype wire

// File: tb/tb_fb_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_fb_write_arbiter
// Brief   : Directed self-checking bench for fb_write_arbiter.
// Rev     : 1.0  initial release
// ============================================================================
module tb_fb_write_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [19:0] cpu_req_addr;
  logic        cpu_req_data;
  logic        fill_start;
  logic [19:0] fill_base;
  logic [16:0] fill_count;
  logic        fill_data;
  logic        fill_busy;
  logic        fill_done;
  logic        arb_we;
  logic [19:0] arb_addr;
  logic        arb_din;

  int n_tests = 0;
  int n_fail  = 0;

  fb_write_arbiter #(
    .CPU_FIFO_DEPTH(4),
    .PIX_PER_PLANE (98304)
  ) u_dut (
    .clk          (clk),
    .rst          (rst),
    .cpu_req_valid(cpu_req_valid),
    .cpu_req_ready(cpu_req_ready),
    .cpu_req_addr (cpu_req_addr),
    .cpu_req_data (cpu_req_data),
    .fill_start   (fill_start),
    .fill_base    (fill_base),
    .fill_count   (fill_count),
    .fill_data    (fill_data),
    .fill_busy    (fill_busy),
    .fill_done    (fill_done),
    .arb_we       (arb_we),
    .arb_addr     (arb_addr),
    .arb_din      (arb_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic arbw(input string tag, input logic [19:0] a, input logic d);
    check({tag, ".we"},   32'(arb_we),   32'd1);
    check({tag, ".addr"}, 32'(arb_addr), 32'(a));
    check({tag, ".din"},  32'(arb_din),  32'(d));
  endtask

  task automatic arb0(input string tag);
    check({tag, ".we"}, 32'(arb_we), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    cpu_req_valid = 1'b0; cpu_req_addr = '0; cpu_req_data = 1'b0;
    fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_data = 1'b0;

    // ---------------- reset state
    tick(); tick();
    check("rst.we",    32'(arb_we),        32'd0);
    check("rst.addr",  32'(arb_addr),      32'd0);
    check("rst.din",   32'(arb_din),       32'd0);
    check("rst.busy",  32'(fill_busy),     32'd0);
    check("rst.done",  32'(fill_done),     32'd0);
    check("rst.ready", 32'(cpu_req_ready), 32'd0);
    rst = 1'b0;
    tick();
    check("post_rst.ready", 32'(cpu_req_ready), 32'd1);

    // ---------------- single CPU write, two-cycle latency, then hold
    cpu_req_valid = 1'b1; cpu_req_addr = 20'h20005; cpu_req_data = 1'b1;
    tick();
    cpu_req_valid = 1'b0;
    arb0("cpu1.n1");
    tick();
    arbw("cpu1.n2", 20'h20005, 1'b1);
    tick();
    arb0("cpu1.n3");
    check("cpu1.hold_addr", 32'(arb_addr), 32'h20005);
    check("cpu1.hold_din",  32'(arb_din),  32'd1);

    // ---------------- fill 4 pixels from 0
    fill_start = 1'b1; fill_base = 20'h00000; fill_count = 17'd4; fill_data = 1'b1;
    tick();
    fill_start = 1'b0;
    check("fill4.busy", 32'(fill_busy), 32'd1);
    arb0("fill4.c0");
    tick(); arbw("fill4.p0", 20'h00000, 1'b1);
    tick(); arbw("fill4.p1", 20'h00001, 1'b1);
    tick(); arbw("fill4.p2", 20'h00002, 1'b1);
    check("fill4.done_early", 32'(fill_done), 32'd0);
    tick(); arbw("fill4.p3", 20'h00003, 1'b1);
    check("fill4.done", 32'(fill_done), 32'd1);
    check("fill4.busy_end", 32'(fill_busy), 32'd0);
    tick();
    arb0("fill4.after");
    check("fill4.done_clr", 32'(fill_done), 32'd0);
    check("fill4.busy_after", 32'(fill_busy), 32'd0);

    // ---------------- wrap: plane 3, pixel 98302
    fill_start = 1'b1; fill_base = 20'h77FFE; fill_count = 17'd3; fill_data = 1'b0;
    tick();
    fill_start = 1'b0;
    tick(); arbw("wrap.p0", 20'h77FFE, 1'b0);
    tick(); arbw("wrap.p1", 20'h77FFF, 1'b0);
    tick(); arbw("wrap.p2", 20'h60000, 1'b0);
    check("wrap.done", 32'(fill_done), 32'd1);
    tick(); arb0("wrap.after");

    // ---------------- zero count rejected
    fill_start = 1'b1; fill_base = 20'h00010; fill_count = 17'd0; fill_data = 1'b1;
    tick();
    fill_start = 1'b0;
    check("cnt0.done", 32'(fill_done), 32'd1);
    check("cnt0.busy", 32'(fill_busy), 32'd0);
    arb0("cnt0.c1");
    tick();
    check("cnt0.done_clr", 32'(fill_done), 32'd0);
    arb0("cnt0.c2");

    // ---------------- base pixel out of range rejected
    fill_start = 1'b1; fill_base = 20'h18000; fill_count = 17'd5; fill_data = 1'b1;
    tick();
    fill_start = 1'b0;
    check("oob.done", 32'(fill_done), 32'd1);
    check("oob.busy", 32'(fill_busy), 32'd0);
    arb0("oob.c1");
    tick();
    arb0("oob.c2");
    check("oob.done_clr", 32'(fill_done), 32'd0);

    // ---------------- fill_start during RUN ignored
    fill_start = 1'b1; fill_base = 20'h40010; fill_count = 17'd3; fill_data = 1'b1;
    tick();
    fill_base = 20'h00000; fill_count = 17'd5; fill_data = 1'b0;
    tick();
    fill_start = 1'b0;
    arbw("ign.p0", 20'h40010, 1'b1);
    tick(); arbw("ign.p1", 20'h40011, 1'b1);
    tick(); arbw("ign.p2", 20'h40012, 1'b1);
    check("ign.done", 32'(fill_done), 32'd1);
    tick();
    arb0("ign.after");
    check("ign.busy", 32'(fill_busy), 32'd0);

    // ---------------- contention: fill 4 + CPU burst 4, CPU first
    fill_start = 1'b1; fill_base = 20'h20100; fill_count = 17'd4; fill_data = 1'b0;
    cpu_req_valid = 1'b1; cpu_req_addr = 20'h10001; cpu_req_data = 1'b1;
    tick();
    fill_start = 1'b0;
    cpu_req_addr = 20'h10002; cpu_req_data = 1'b0;
    arb0("cont.c1");
    tick();
    arbw("cont.c2", 20'h10001, 1'b1);
    cpu_req_addr = 20'h10003; cpu_req_data = 1'b1;
    tick();
    arbw("cont.c3", 20'h20100, 1'b0);
    check("cont.ready", 32'(cpu_req_ready), 32'd1);
    cpu_req_addr = 20'h10004; cpu_req_data = 1'b0;
    tick();
    cpu_req_valid = 1'b0;
    arbw("cont.c4", 20'h10002, 1'b0);
    tick(); arbw("cont.c5", 20'h20101, 1'b0);
    tick(); arbw("cont.c6", 20'h10003, 1'b1);
    tick(); arbw("cont.c7", 20'h20102, 1'b0);
    tick(); arbw("cont.c8", 20'h10004, 1'b0);
    tick(); arbw("cont.c9", 20'h20103, 1'b0);
    check("cont.done", 32'(fill_done), 32'd1);
    tick(); arb0("cont.c10");

    // ---------------- FIFO fills under contention; fill wins first here
    fill_start = 1'b1; fill_base = 20'h50000; fill_count = 17'd10; fill_data = 1'b1;
    cpu_req_valid = 1'b1; cpu_req_addr = 20'h30001; cpu_req_data = 1'b1;
    tick();
    fill_start = 1'b0;
    cpu_req_addr = 20'h30002; cpu_req_data = 1'b0;
    arb0("full.s1");
    tick();
    arbw("full.s2", 20'h50000, 1'b1);
    cpu_req_addr = 20'h30003; cpu_req_data = 1'b1;
    tick();
    arbw("full.s3", 20'h30001, 1'b1);
    cpu_req_addr = 20'h30004; cpu_req_data = 1'b0;
    tick();
    arbw("full.s4", 20'h50001, 1'b1);
    cpu_req_addr = 20'h30005; cpu_req_data = 1'b1;
    tick();
    arbw("full.s5", 20'h30002, 1'b0);
    check("full.s5_ready", 32'(cpu_req_ready), 32'd1);
    cpu_req_addr = 20'h30006; cpu_req_data = 1'b0;
    tick();
    arbw("full.s6", 20'h50002, 1'b1);
    check("full.s6_ready", 32'(cpu_req_ready), 32'd0);
    check("full.s6_busy",  32'(fill_busy),     32'd1);
    cpu_req_valid = 1'b0;

    // ---------------- asynchronous reset mid-fill with a full FIFO
    rst = 1'b1;
    #1;
    check("mrst.we",    32'(arb_we),        32'd0);
    check("mrst.busy",  32'(fill_busy),     32'd0);
    check("mrst.done",  32'(fill_done),     32'd0);
    check("mrst.ready", 32'(cpu_req_ready), 32'd0);
    check("mrst.addr",  32'(arb_addr),      32'd0);
    tick();
    check("mrst.done_hold", 32'(fill_done), 32'd0);
    rst = 1'b0;
    tick();
    check("mrst.ready_up", 32'(cpu_req_ready), 32'd1);
    check("mrst.done_r1",  32'(fill_done),     32'd0);
    arb0("mrst.r1");
    tick(); arb0("mrst.r2");
    check("mrst.done_r2", 32'(fill_done), 32'd0);
    tick(); arb0("mrst.r3");

    // ---------------- normal fill after reset
    fill_start = 1'b1; fill_base = 20'h10003; fill_count = 17'd2; fill_data = 1'b0;
    tick();
    fill_start = 1'b0;
    check("post.busy", 32'(fill_busy), 32'd1);
    tick(); arbw("post.p0", 20'h10003, 1'b0);
    tick(); arbw("post.p1", 20'h10004, 1'b0);
    check("post.done", 32'(fill_done), 32'd1);
    tick();
    arb0("post.after");
    check("post.idle", 32'(fill_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
